// File: rtl/process_switch_controller_pkg.sv
// Shared process-control definitions: switch FSM state encoding and default widths.
`default_nettype none

package process_switch_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    LOAD   = 3'd2,
    COMMIT = 3'd3,
    ACK    = 3'd4
  } state_e;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int IDX_W_DEFAULT    = 5;
  localparam int PID_W_DEFAULT    = 4;

endpackage

`default_nettype wire

// File: rtl/process_switch_controller_ctx_index_counter.sv
// Context register index counter: clearable up-counter with terminal-count flag at NUM_REGS-1.
`default_nettype none

module ctx_index_counter #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Clear has priority so a terminal cycle can both finish and rewind.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/process_switch_controller.sv
// Process-switch sequencer: saves the running context, loads the target context,
// then issues a one-cycle commit to the control-signal register, stalling the front end.
`default_nettype none

module process_switch_controller
  import process_switch_controller_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int IDX_W    = IDX_W_DEFAULT,
  parameter int PID_W    = PID_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             switch_req,
  input  logic [PID_W-1:0] switch_pid,
  output logic             exec_process,
  output logic             select_proc_reg_write,
  output logic             select_proc_reg_read,
  output logic [IDX_W-1:0] ctx_reg_idx,
  output logic [PID_W-1:0] ctx_pid,
  output logic [PID_W-1:0] cur_pid,
  output logic             stall,
  output logic             switch_done
);

  state_e           state_q, state_d;
  logic [PID_W-1:0] target_q, target_d;
  logic [PID_W-1:0] cur_pid_q, cur_pid_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [IDX_W-1:0] cnt;
  logic             cnt_tc;

  ctx_index_counter #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_ctx_index_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cur_pid_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_pid_q <= cur_pid_d;
    end
  end

  // Outputs depend only on registered state so nothing combinational
  // from switch_req/switch_pid reaches the pipeline register.
  always_comb begin
    state_d               = state_q;
    target_d              = target_q;
    cur_pid_d             = cur_pid_q;
    cnt_clr               = 1'b0;
    cnt_inc               = 1'b0;
    exec_process          = 1'b0;
    select_proc_reg_write = 1'b0;
    select_proc_reg_read  = 1'b0;
    ctx_reg_idx           = '0;
    ctx_pid               = cur_pid_q;
    stall                 = 1'b0;
    switch_done           = 1'b0;

    case (state_q)
      IDLE: begin
        if (switch_req) begin
          if (switch_pid != cur_pid_q) begin
            target_d = switch_pid;
            cnt_clr  = 1'b1;
            state_d  = SAVE;
          end else begin
            state_d  = ACK;
          end
        end
      end

      SAVE: begin
        select_proc_reg_write = 1'b1;
        stall                 = 1'b1;
        ctx_reg_idx           = cnt;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = LOAD;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      LOAD: begin
        select_proc_reg_read = 1'b1;
        stall                = 1'b1;
        ctx_pid              = target_q;
        ctx_reg_idx          = cnt;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = COMMIT;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      COMMIT: begin
        exec_process = 1'b1;
        stall        = 1'b1;
        ctx_pid      = target_q;
        cur_pid_d    = target_q;
        state_d      = ACK;
      end

      ACK: begin
        switch_done = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cur_pid = cur_pid_q;

endmodule

`default_nettype wire

// File: tb/tb_process_switch_controller.sv
// Self-checking bench: table-driven switch sequences on NUM_REGS=4 plus
// asynchronous-reset and NUM_REGS=2 boundary sequences.
`default_nettype none

module tb_process_switch_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, req2;
  logic [3:0] pid, pid2;

  logic       ex, wr, rd, st, dn;
  logic [1:0] idx;
  logic [3:0] ctx, cur;

  logic       ex2, wr2, rd2, st2, dn2;
  logic [0:0] idx2;
  logic [3:0] ctx2, cur2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  process_switch_controller #(.NUM_REGS(4), .IDX_W(2), .PID_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .switch_req(req), .switch_pid(pid),
    .exec_process(ex), .select_proc_reg_write(wr), .select_proc_reg_read(rd),
    .ctx_reg_idx(idx), .ctx_pid(ctx), .cur_pid(cur), .stall(st), .switch_done(dn)
  );

  process_switch_controller #(.NUM_REGS(2), .IDX_W(1), .PID_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .switch_req(req2), .switch_pid(pid2),
    .exec_process(ex2), .select_proc_reg_write(wr2), .select_proc_reg_read(rd2),
    .ctx_reg_idx(idx2), .ctx_pid(ctx2), .cur_pid(cur2), .stall(st2), .switch_done(dn2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The three bank/commit controls must never overlap.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("mutex_main", 32'($countones({wr, rd, ex}) <= 1), 32'd1);
      chk("mutex_nr2", 32'($countones({wr2, rd2, ex2}) <= 1), 32'd1);
    end
  end

  typedef struct {
    logic       req;
    logic [3:0] pid;
    logic       wr, rd, ex, st, dn;
    logic [1:0] idx;
    logic [3:0] ctx, cur;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic r, input int p, input logic w, input logic d,
                              input logic e, input logic s, input logic a,
                              input int i, input int c, input int u);
    vec_t v;
    v.req = r; v.pid = 4'(p); v.wr = w; v.rd = d; v.ex = e; v.st = s; v.dn = a;
    v.idx = 2'(i); v.ctx = 4'(c); v.cur = 4'(u);
    return v;
  endfunction

  initial begin
    int  edges;
    int  wseq[$];
    int  rseq[$];

    // Switch 0->5 with switch_pid changed to 7 mid-SAVE (ignored), then same-PID
    // request, then request held through ACK producing back-to-back switch 5->2.
    tbl[0]  = mk(1, 5, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 7, 1, 0, 0, 1, 0, 1, 0, 0);
    tbl[2]  = mk(1, 7, 1, 0, 0, 1, 0, 2, 0, 0);
    tbl[3]  = mk(1, 7, 1, 0, 0, 1, 0, 3, 0, 0);
    tbl[4]  = mk(1, 7, 0, 1, 0, 1, 0, 0, 5, 0);
    tbl[5]  = mk(1, 7, 0, 1, 0, 1, 0, 1, 5, 0);
    tbl[6]  = mk(1, 7, 0, 1, 0, 1, 0, 2, 5, 0);
    tbl[7]  = mk(1, 7, 0, 1, 0, 1, 0, 3, 5, 0);
    tbl[8]  = mk(1, 7, 0, 0, 1, 1, 0, 0, 5, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5, 5);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    tbl[11] = mk(1, 5, 0, 0, 0, 0, 1, 0, 5, 5);
    tbl[12] = mk(1, 2, 0, 0, 0, 0, 0, 0, 5, 5);
    tbl[13] = mk(1, 2, 1, 0, 0, 1, 0, 0, 5, 5);
    tbl[14] = mk(0, 0, 1, 0, 0, 1, 0, 1, 5, 5);
    tbl[15] = mk(0, 0, 1, 0, 0, 1, 0, 2, 5, 5);
    tbl[16] = mk(0, 0, 1, 0, 0, 1, 0, 3, 5, 5);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 0, 2, 5);
    tbl[18] = mk(0, 0, 0, 1, 0, 1, 0, 1, 2, 5);
    tbl[19] = mk(0, 0, 0, 1, 0, 1, 0, 2, 2, 5);
    tbl[20] = mk(0, 0, 0, 1, 0, 1, 0, 3, 2, 5);
    tbl[21] = mk(0, 0, 0, 0, 1, 1, 0, 0, 2, 5);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 2);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);

    rst_n = 1'b0; req = 1'b0; pid = '0; req2 = 1'b0; pid2 = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset_outputs", 32'({ex, wr, rd, st, dn, idx, ctx, cur}), 32'd0);

    for (int i = 0; i < 24; i++) begin
      req = tbl[i].req;
      pid = tbl[i].pid;
      step();
      chk($sformatf("v%0d_write", i), 32'(wr), 32'(tbl[i].wr));
      chk($sformatf("v%0d_read", i),  32'(rd), 32'(tbl[i].rd));
      chk($sformatf("v%0d_exec", i),  32'(ex), 32'(tbl[i].ex));
      chk($sformatf("v%0d_stall", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("v%0d_done", i),  32'(dn), 32'(tbl[i].dn));
      chk($sformatf("v%0d_idx", i),   32'(idx), 32'(tbl[i].idx));
      chk($sformatf("v%0d_ctx", i),   32'(ctx), 32'(tbl[i].ctx));
      chk($sformatf("v%0d_cur", i),   32'(cur), 32'(tbl[i].cur));
    end

    // Reset asserted mid-LOAD at cnt=2 must clear outputs before the next edge.
    req = 1'b1; pid = 4'd3;
    step();
    req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("preabort_read", 32'(rd), 32'd1);
    chk("preabort_idx", 32'(idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({ex, wr, rd, st, dn, idx, ctx, cur}), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 32'({ex, wr, rd, st, dn, idx, ctx, cur}), 32'd0);
    req = 1'b1; pid = 4'd0;
    step();
    chk("post_reset_same_pid_done", 32'(dn), 32'd1);
    chk("post_reset_same_pid_stall", 32'(st), 32'd0);
    req = 1'b0;
    step();

    // NUM_REGS=2 boundary: idx 0,1 then 0,1; done six edges after acceptance.
    req2 = 1'b1; pid2 = 4'd9;
    edges = 0;
    while (edges < 20) begin
      step();
      edges++;
      if (wr2) wseq.push_back(int'(idx2));
      if (rd2) rseq.push_back(int'(idx2));
      if (dn2) break;
    end
    req2 = 1'b0;
    chk("nr2_done_seen", 32'(dn2), 32'd1);
    chk("nr2_done_latency", 32'(edges), 32'd6);
    chk("nr2_cur_pid", 32'(cur2), 32'd9);
    chk("nr2_write_len", 32'(wseq.size()), 32'd2);
    chk("nr2_read_len", 32'(rseq.size()), 32'd2);
    if (wseq.size() == 2) begin
      chk("nr2_write_idx0", 32'(wseq[0]), 32'd0);
      chk("nr2_write_idx1", 32'(wseq[1]), 32'd1);
    end
    if (rseq.size() == 2) begin
      chk("nr2_read_idx0", 32'(rseq[0]), 32'd0);
      chk("nr2_read_idx1", 32'(rseq[1]), 32'd1);
    end
    step();
    chk("nr2_back_idle", 32'({st2, dn2, idx2}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/process_switch_controller.md
Name: process_switch_controller

Overview:
- Control stage directly upstream of the control-signal pipeline register; generates its three inputs: exec_process, select_proc_reg_write, select_proc_reg_read.
- On a process-switch request, sequences a context save of the current process's register bank, then a context load of the target bank, then a one-cycle commit.
- Stalls the front end for the whole sequence.

Parameters:
- NUM_REGS, 32, registers per process context (>=2).
- IDX_W, 5, width of ctx_reg_idx; must satisfy 2**IDX_W >= NUM_REGS.
- PID_W, 4, process-ID width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- switch_req  input  1  request a switch; level, held until switch_done.
- switch_pid  input  PID_W  target process ID; valid while switch_req=1.
- exec_process  output  1  one-cycle commit pulse to the control-signal register.
- select_proc_reg_write  output  1  save phase: write current context to process bank.
- select_proc_reg_read  output  1  load phase: read target context from process bank.
- ctx_reg_idx  output  IDX_W  register index being saved or loaded.
- ctx_pid  output  PID_W  bank being addressed.
- cur_pid  output  PID_W  currently running process.
- stall  output  1  holds upstream fetch/decode.
- switch_done  output  1  one-cycle acknowledge of switch_req.

Behaviour:
- Clocking and reset: one clock domain. rst_n is asynchronous active-low; all flops clear immediately on assertion, release is synchronous to clk.
- Reset values: state=IDLE, cnt=0, target=0, cur_pid=0. All outputs are 0.
- Outputs are decoded only from registered state, cnt, target and cur_pid. There is no combinational input-to-output path.
- States: IDLE, SAVE, LOAD, COMMIT, ACK.
- IDLE:
  - All controls 0, stall=0, ctx_pid=cur_pid, ctx_reg_idx=0.
  - switch_req=1 and switch_pid!=cur_pid: latch target<=switch_pid, cnt<=0, go to SAVE.
  - switch_req=1 and switch_pid==cur_pid: go to ACK with no bank traffic.
- SAVE:
  - select_proc_reg_write=1, stall=1, ctx_pid=cur_pid, ctx_reg_idx=cnt.
  - cnt increments each cycle.
  - At cnt==NUM_REGS-1: cnt<=0, go to LOAD.
- LOAD:
  - select_proc_reg_read=1, stall=1, ctx_pid=target, ctx_reg_idx=cnt.
  - At cnt==NUM_REGS-1: cnt<=0, go to COMMIT.
- COMMIT:
  - exec_process=1, stall=1, ctx_pid=target.
  - cur_pid<=target; go to ACK.
- ACK:
  - switch_done=1, stall=0; go to IDLE.
  - switch_req is expected low in the following cycle. If it is still high, it is treated as a new request.
- Latency: a request accepted at edge N gives SAVE for NUM_REGS cycles, then LOAD for NUM_REGS cycles, then COMMIT for 1, then ACK for 1. switch_done is high in cycle N+2*NUM_REGS+2 after acceptance. Same-PID request: switch_done in cycle N+1.
- Mutual exclusion: select_proc_reg_write, select_proc_reg_read and exec_process are never high simultaneously.
- Request changes while busy: switch_req and switch_pid changes during SAVE/LOAD/COMMIT are ignored. target is frozen at acceptance.
- Counter: wraps to 0 only by state transition, never by overflow. ctx_reg_idx is 0 outside SAVE/LOAD.
- Reset mid-sequence: aborts immediately to IDLE with cur_pid=0. A partial save is not rolled back.

Decomposition:
- Shared package (process-control constants): state encoding enum (IDLE=0, SAVE=1, LOAD=2, COMMIT=3, ACK=4) and the PID_W / IDX_W defaults.
- One natural sub-module: ctx_index_counter, a loadable/clearable up-counter with terminal-count flag at NUM_REGS-1. The FSM stays in the top module.

Test Plan:
- Reset state: NUM_REGS=4. Assert rst_n=0 mid-LOAD (cnt=2) → all outputs 0 asynchronously, before the next clk edge; cur_pid=0. After release, state is IDLE.
- Full switch 0→5: switch_req=1, switch_pid=5.
  - 4 cycles write=1 with ctx_pid=0, idx 0,1,2,3.
  - Then 4 cycles read=1 with ctx_pid=5, idx 0..3.
  - Then exec_process=1 for 1 cycle, then switch_done=1 with cur_pid=5.
  - stall=1 for exactly 9 cycles.
- Same-PID request: cur_pid=5, request pid=5 → switch_done=1 next cycle; write, read and exec_process never assert; stall stays 0.
- Request change while busy: during SAVE change switch_pid to 7 → sequence completes with ctx_pid=5 in LOAD and cur_pid=5.
- Back-to-back: hold switch_req=1 through ACK with pid=2 → a new SAVE starts with ctx_pid=5. Check mutual exclusion of the three controls every cycle (assertion).
- Boundary: NUM_REGS=2, IDX_W=1 → idx sequence 0,1,0,1. switch_done at acceptance+6.
